// File: rtl/cam_pkg.sv
// cam_pkg
//   Shared constants and helpers for the cam_multi tag store and its
//   priority encoder. Nothing here holds state; it only fixes defaults
//   and the rule that turns an entry count into an address width.
package cam_pkg;

  localparam int CAM_DEFAULT_DW    = 8;
  localparam int CAM_DEFAULT_DEPTH = 16;

  // Address width needed to index 'depth' entries. A single-entry vector
  // still needs a one-bit index port, so the result never drops below 1.
  function automatic int camAddrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cam_prio_enc.sv
// cam_prio_enc
//   Priority encoder over an N-bit request vector. Reports the index of the
//   winning bit (highest index when HIGH_PRI!=0, lowest otherwise), whether
//   any bit is set, and whether two or more bits are set.
//
// Ports
//   i_vec   : request vector, one bit per entry
//   o_idx   : winning index, 0 when nothing is set
//   o_any   : at least one bit set
//   o_multi : two or more bits set
module cam_prio_enc
  import cam_pkg::*;
#(
  parameter int N        = 16,
  parameter int HIGH_PRI = 1,
  localparam int IW      = camAddrWidth(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any,
  output logic          o_multi
);

  // A single scan does all three jobs: the "any" flag doubles as the
  // "already seen one" marker that turns a second set bit into multi,
  // and it also stops later bits from replacing the index in lowest-first mode.
  always_comb begin
    o_idx   = '0;
    o_any   = 1'b0;
    o_multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_vec[i]) begin
        if (o_any) begin
          o_multi = 1'b1;
        end
        if ((HIGH_PRI != 0) || !o_any) begin
          o_idx = IW'(i);
        end
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_multi.sv
// cam_multi
//   Parametrised content-addressable tag store with per-entry valid bits.
//   Maintenance side: clear-all, direct write, insert into first free slot
//   (optionally refusing duplicates), and invalidate. Search side: one
//   lookup per cycle with a one-cycle registered result. Searches always
//   see the contents as they were before the same clock edge.
//
// Ports
//   clk, rst       : clock, asynchronous active-high reset
//   clr            : invalidate every entry
//   wen            : write wdata to entry waddr and mark it valid
//   ins_en         : insert wdata into the lowest-index free entry
//   inv_en         : invalidate entry waddr
//   waddr, wdata   : address/data for the maintenance ops
//   ren, sdata     : search request and key
//   dout           : registered matching address
//   hit, multi_hit : one / two-or-more valid entries matched
//   rvalid         : the three search outputs belong to last cycle's ren
//   ins_done/fail/dup : one-cycle insert result pulses
//   ins_addr       : address written or found by the last insert
//   count, full    : number of valid entries, and count == DEPTH
module cam_multi
  import cam_pkg::*;
#(
  parameter int DW       = CAM_DEFAULT_DW,
  parameter int DEPTH    = CAM_DEFAULT_DEPTH,
  parameter int HIGH_PRI = 1,
  parameter int NO_DUP   = 0,
  localparam int AW      = camAddrWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wen,
  input  logic          ins_en,
  input  logic          inv_en,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  input  logic [DW-1:0] sdata,
  output logic [AW-1:0] dout,
  output logic          hit,
  output logic          multi_hit,
  output logic          rvalid,
  output logic          ins_done,
  output logic          ins_fail,
  output logic          ins_dup,
  output logic [AW-1:0] ins_addr,
  output logic [AW:0]   count,
  output logic          full
);

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  // Storage. The data array has no reset; the valid bits alone decide
  // whether an entry can ever match.
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [AW:0]      r_count;

  // Registered search and insert results.
  logic [AW-1:0] r_dout;
  logic          r_hit;
  logic          r_multiHit;
  logic          r_rvalid;
  logic          r_insDone;
  logic          r_insFail;
  logic          r_insDup;
  logic [AW-1:0] r_insAddr;

  // Per-entry compare vectors and encoder results.
  logic [DEPTH-1:0] w_searchVec;
  logic [DEPTH-1:0] w_dupVec;
  logic [DEPTH-1:0] w_freeVec;
  logic [AW-1:0]    w_searchIdx;
  logic             w_searchAny;
  logic             w_searchMulti;
  logic [AW-1:0]    w_dupIdx;
  logic             w_dupAny;
  logic             w_dupMulti;
  logic [AW-1:0]    w_freeIdx;
  logic             w_freeAny;
  logic             w_freeMulti;

  // Next-state of the maintenance side.
  logic [DEPTH-1:0] w_validNext;
  logic [AW:0]      w_countNext;
  logic             w_dataWe;
  logic [AW-1:0]    w_dataAddr;
  logic             w_insDone;
  logic             w_insFail;
  logic             w_insDup;
  logic [AW-1:0]    w_insAddrNext;

  // Only the "any"/index results of the free-slot and duplicate encoders
  // are needed; their multi flags are deliberately left unused.
  logic w_unused;
  assign w_unused = w_dupMulti ^ w_freeMulti;

  // Two compare banks: the search key against every entry, and the write
  // data against every entry for duplicate detection on insert.
  always_comb begin
    w_searchVec = '0;
    w_dupVec    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_searchVec[i] = r_valid[i] && (r_data[i] == sdata);
      w_dupVec[i]    = r_valid[i] && (r_data[i] == wdata);
    end
  end

  assign w_freeVec = ~r_valid;

  cam_prio_enc #(
    .N        (DEPTH),
    .HIGH_PRI (HIGH_PRI)
  ) u_searchEnc (
    .i_vec   (w_searchVec),
    .o_idx   (w_searchIdx),
    .o_any   (w_searchAny),
    .o_multi (w_searchMulti)
  );

  // Insert placement is always lowest-first, whatever the search priority.
  cam_prio_enc #(
    .N        (DEPTH),
    .HIGH_PRI (0)
  ) u_freeEnc (
    .i_vec   (w_freeVec),
    .o_idx   (w_freeIdx),
    .o_any   (w_freeAny),
    .o_multi (w_freeMulti)
  );

  cam_prio_enc #(
    .N        (DEPTH),
    .HIGH_PRI (0)
  ) u_dupEnc (
    .i_vec   (w_dupVec),
    .o_idx   (w_dupIdx),
    .o_any   (w_dupAny),
    .o_multi (w_dupMulti)
  );

  // One maintenance op per cycle: clr beats wen beats ins_en beats inv_en,
  // and the losers vanish without any pulse. The count is tracked
  // incrementally: it only moves when a valid bit actually changes state.
  always_comb begin
    w_validNext   = r_valid;
    w_countNext   = r_count;
    w_dataWe      = 1'b0;
    w_dataAddr    = waddr;
    w_insDone     = 1'b0;
    w_insFail     = 1'b0;
    w_insDup      = 1'b0;
    w_insAddrNext = r_insAddr;
    if (clr) begin
      w_validNext = '0;
      w_countNext = '0;
    end else if (wen) begin
      w_validNext[waddr] = 1'b1;
      w_dataWe           = 1'b1;
      if (!r_valid[waddr]) begin
        w_countNext = r_count + CNT_ONE;
      end
    end else if (ins_en) begin
      // A duplicate is reported even when the store is full.
      if ((NO_DUP != 0) && w_dupAny) begin
        w_insDup      = 1'b1;
        w_insAddrNext = w_dupIdx;
      end else if (w_freeAny) begin
        w_validNext[w_freeIdx] = 1'b1;
        w_dataWe               = 1'b1;
        w_dataAddr             = w_freeIdx;
        w_insDone              = 1'b1;
        w_insAddrNext          = w_freeIdx;
        w_countNext            = r_count + CNT_ONE;
      end else begin
        w_insFail = 1'b1;
      end
    end else if (inv_en) begin
      w_validNext[waddr] = 1'b0;
      if (r_valid[waddr]) begin
        w_countNext = r_count - CNT_ONE;
      end
    end
  end

  // Data array write port. Held off while reset is asserted so an op that
  // reset interrupts leaves nothing behind.
  always_ff @(posedge clk) begin
    if (w_dataWe && !rst) begin
      r_data[w_dataAddr] <= wdata;
    end
  end

  // Valid bits, occupancy and insert result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= '0;
      r_count   <= '0;
      r_insDone <= 1'b0;
      r_insFail <= 1'b0;
      r_insDup  <= 1'b0;
      r_insAddr <= '0;
    end else begin
      r_valid   <= w_validNext;
      r_count   <= w_countNext;
      r_insDone <= w_insDone;
      r_insFail <= w_insFail;
      r_insDup  <= w_insDup;
      r_insAddr <= w_insAddrNext;
    end
  end

  // Search result registers. Without a request every field returns to zero,
  // so a stale hit can never be mistaken for a fresh one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout     <= '0;
      r_hit      <= 1'b0;
      r_multiHit <= 1'b0;
      r_rvalid   <= 1'b0;
    end else begin
      r_rvalid   <= ren;
      r_dout     <= (ren && w_searchAny) ? w_searchIdx : '0;
      r_hit      <= ren && w_searchAny;
      r_multiHit <= ren && w_searchMulti;
    end
  end

  assign dout      = r_dout;
  assign hit       = r_hit;
  assign multi_hit = r_multiHit;
  assign rvalid    = r_rvalid;
  assign ins_done  = r_insDone;
  assign ins_fail  = r_insFail;
  assign ins_dup   = r_insDup;
  assign ins_addr  = r_insAddr;
  assign count     = r_count;
  assign full      = (r_count == CNT_FULL);

endmodule

// File: tb/tb_cam_multi.sv
// tb_cam_multi
//   Drives two cam_multi instances with identical stimulus:
//   dut 0 = highest-index priority, duplicates allowed;
//   dut 1 = lowest-index priority, duplicates refused.
//   Expected values come from a list-based model of the store plus a
//   table of hand-derived results for the directed search sequence.
module tb_cam_multi;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int NDUT  = 2;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic          clr    = 1'b0;
  logic          wen    = 1'b0;
  logic          insEn  = 1'b0;
  logic          invEn  = 1'b0;
  logic [AW-1:0] waddr  = '0;
  logic [DW-1:0] wdata  = '0;
  logic          ren    = 1'b0;
  logic [DW-1:0] sdata  = '0;

  logic [AW-1:0] dout     [NDUT];
  logic          hit      [NDUT];
  logic          multiHit [NDUT];
  logic          rvalid   [NDUT];
  logic          insDone  [NDUT];
  logic          insFail  [NDUT];
  logic          insDup   [NDUT];
  logic [AW-1:0] insAddr  [NDUT];
  logic [AW:0]   count    [NDUT];
  logic          full     [NDUT];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_multi #(.DW(DW), .DEPTH(DEPTH), .HIGH_PRI(1), .NO_DUP(0)) dutA (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .ins_en(insEn), .inv_en(invEn),
    .waddr(waddr), .wdata(wdata), .ren(ren), .sdata(sdata),
    .dout(dout[0]), .hit(hit[0]), .multi_hit(multiHit[0]), .rvalid(rvalid[0]),
    .ins_done(insDone[0]), .ins_fail(insFail[0]), .ins_dup(insDup[0]),
    .ins_addr(insAddr[0]), .count(count[0]), .full(full[0])
  );

  cam_multi #(.DW(DW), .DEPTH(DEPTH), .HIGH_PRI(0), .NO_DUP(1)) dutB (
    .clk(clk), .rst(rst), .clr(clr), .wen(wen), .ins_en(insEn), .inv_en(invEn),
    .waddr(waddr), .wdata(wdata), .ren(ren), .sdata(sdata),
    .dout(dout[1]), .hit(hit[1]), .multi_hit(multiHit[1]), .rvalid(rvalid[1]),
    .ins_done(insDone[1]), .ins_fail(insFail[1]), .ins_dup(insDup[1]),
    .ins_addr(insAddr[1]), .count(count[1]), .full(full[1])
  );

  // Reference model: the store is just an array of (valid, data) pairs;
  // outputs are derived from the list of matching indices.
  int mData    [NDUT][DEPTH];
  bit mValid   [NDUT][DEPTH];
  int mInsAddr [NDUT];
  int eDout [NDUT], eHit [NDUT], eMulti [NDUT], eRvalid [NDUT];
  int eDone [NDUT], eFail [NDUT], eDup [NDUT], eCount [NDUT];

  task automatic modelReset();
    for (int k = 0; k < NDUT; k++) begin
      for (int i = 0; i < DEPTH; i++) mValid[k][i] = 1'b0;
      mInsAddr[k] = 0;
      eDout[k] = 0; eHit[k] = 0; eMulti[k] = 0; eRvalid[k] = 0;
      eDone[k] = 0; eFail[k] = 0; eDup[k] = 0; eCount[k] = 0;
    end
  endtask

  task automatic modelStep();
    int hits[$];
    int dupAt;
    int freeAt;
    for (int k = 0; k < NDUT; k++) begin
      hits.delete();
      for (int i = 0; i < DEPTH; i++)
        if (mValid[k][i] && mData[k][i] == int'(sdata)) hits.push_back(i);
      eRvalid[k] = int'(ren);
      eHit[k]    = (ren && hits.size() > 0) ? 1 : 0;
      eMulti[k]  = (ren && hits.size() > 1) ? 1 : 0;
      eDout[k]   = 0;
      if (ren && hits.size() > 0) eDout[k] = (k == 0) ? hits[$] : hits[0];
      eDone[k] = 0; eFail[k] = 0; eDup[k] = 0;
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mValid[k][i] = 1'b0;
      end else if (wen) begin
        mValid[k][waddr] = 1'b1;
        mData[k][waddr]  = int'(wdata);
      end else if (insEn) begin
        dupAt = -1;
        freeAt = -1;
        for (int i = 0; i < DEPTH; i++) begin
          if (dupAt < 0 && mValid[k][i] && mData[k][i] == int'(wdata)) dupAt = i;
          if (freeAt < 0 && !mValid[k][i]) freeAt = i;
        end
        if (k == 1 && dupAt >= 0) begin
          eDup[k] = 1;
          mInsAddr[k] = dupAt;
        end else if (freeAt >= 0) begin
          mValid[k][freeAt] = 1'b1;
          mData[k][freeAt]  = int'(wdata);
          eDone[k] = 1;
          mInsAddr[k] = freeAt;
        end else begin
          eFail[k] = 1;
        end
      end else if (invEn) begin
        mValid[k][waddr] = 1'b0;
      end
      eCount[k] = 0;
      for (int i = 0; i < DEPTH; i++) eCount[k] += int'(mValid[k][i]);
    end
  endtask

  task automatic checkField(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d actual=%0d expected=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < NDUT; k++) begin
      checkField("dout",      k, int'(dout[k]),     eDout[k]);
      checkField("hit",       k, int'(hit[k]),      eHit[k]);
      checkField("multi_hit", k, int'(multiHit[k]), eMulti[k]);
      checkField("rvalid",    k, int'(rvalid[k]),   eRvalid[k]);
      checkField("ins_done",  k, int'(insDone[k]),  eDone[k]);
      checkField("ins_fail",  k, int'(insFail[k]),  eFail[k]);
      checkField("ins_dup",   k, int'(insDup[k]),   eDup[k]);
      checkField("ins_addr",  k, int'(insAddr[k]),  mInsAddr[k]);
      checkField("count",     k, int'(count[k]),    eCount[k]);
      checkField("full",      k, int'(full[k]),     (eCount[k] == DEPTH) ? 1 : 0);
    end
  endtask

  task automatic driveInputs(input logic c, input logic w, input logic ins, input logic inv,
                             input int wa, input int wd, input logic r, input int sd);
    clr = c; wen = w; insEn = ins; invEn = inv;
    waddr = AW'(wa); wdata = DW'(wd); ren = r; sdata = DW'(sd);
  endtask

  // One clock: model consumes the current inputs, DUT sees the edge,
  // outputs are compared 1 ns later.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Reset is asserted between edges; outputs must clear with no clock.
  task automatic doReset();
    rst = 1'b1;
    #2;
    modelReset();
    checkOutput();
    for (int k = 0; k < NDUT; k++) checkField("rst_count", k, int'(count[k]), 0);
    @(negedge clk);
    driveInputs(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic c, w, ins, inv;
    int   wa, wd;
    logic r;
    int   sd;
    int   expDoutA, expDoutB, expHit, expMulti, expRvalid, expCount;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 'h00, 1, 'h00,  0, 0, 0, 0, 1, 0};
    vecs[1]  = '{0, 1, 0, 0, 3, 'hA5, 0, 'h00,  0, 0, 0, 0, 0, 1};
    vecs[2]  = '{0, 1, 0, 0, 9, 'hA5, 0, 'h00,  0, 0, 0, 0, 0, 2};
    vecs[3]  = '{0, 0, 0, 0, 0, 'h00, 1, 'hA5,  9, 3, 1, 1, 1, 2};
    vecs[4]  = '{0, 0, 0, 1, 3, 'h00, 0, 'h00,  0, 0, 0, 0, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 'h00, 1, 'hA5,  9, 9, 1, 0, 1, 1};
    vecs[6]  = '{0, 1, 0, 0, 9, 'h77, 0, 'h00,  0, 0, 0, 0, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 0, 'h00, 1, 'hA5,  0, 0, 0, 0, 1, 1};
    vecs[8]  = '{0, 1, 0, 0, 4, 'h77, 1, 'h77,  9, 9, 1, 0, 1, 2};
    vecs[9]  = '{0, 0, 0, 0, 0, 'h00, 1, 'h77,  9, 4, 1, 1, 1, 2};
    vecs[10] = '{1, 1, 0, 0, 5, 'h77, 1, 'h77,  9, 4, 1, 1, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0, 'h00, 1, 'h77,  0, 0, 0, 0, 1, 0};

    // Directed search / write / clear sequence from hand-derived table.
    doReset();
    for (int v = 0; v < 12; v++) begin
      driveInputs(vecs[v].c, vecs[v].w, vecs[v].ins, vecs[v].inv,
                  vecs[v].wa, vecs[v].wd, vecs[v].r, vecs[v].sd);
      applyStimulus();
      checkField("tbl_dout", 0, int'(dout[0]), vecs[v].expDoutA);
      checkField("tbl_dout", 1, int'(dout[1]), vecs[v].expDoutB);
      for (int k = 0; k < NDUT; k++) begin
        checkField("tbl_hit",    k, int'(hit[k]),      vecs[v].expHit);
        checkField("tbl_multi",  k, int'(multiHit[k]), vecs[v].expMulti);
        checkField("tbl_rvalid", k, int'(rvalid[k]),   vecs[v].expRvalid);
        checkField("tbl_count",  k, int'(count[k]),    vecs[v].expCount);
      end
    end

    // Fill by insertion, then overflow, then duplicate-over-full.
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      driveInputs(0, 0, 1, 0, 0, 'h40 + i, 0, 0);
      applyStimulus();
      for (int k = 0; k < NDUT; k++) begin
        checkField("fill_addr", k, int'(insAddr[k]), i);
        checkField("fill_done", k, int'(insDone[k]), 1);
      end
    end
    for (int k = 0; k < NDUT; k++) checkField("fill_full", k, int'(full[k]), 1);
    driveInputs(0, 0, 1, 0, 0, 'hEE, 0, 0);
    applyStimulus();
    for (int k = 0; k < NDUT; k++) begin
      checkField("ovf_fail",  k, int'(insFail[k]), 1);
      checkField("ovf_count", k, int'(count[k]), 16);
      checkField("ovf_addr",  k, int'(insAddr[k]), 15);
    end
    driveInputs(0, 0, 1, 0, 0, 'h45, 0, 0);
    applyStimulus();
    checkField("dupfull_fail", 0, int'(insFail[0]), 1);
    checkField("dupfull_dup",  1, int'(insDup[1]), 1);
    checkField("dupfull_addr", 1, int'(insAddr[1]), 5);

    // Punch a hole and refill it.
    driveInputs(0, 0, 0, 1, 5, 0, 0, 0);
    applyStimulus();
    driveInputs(0, 0, 1, 0, 0, 'h3C, 0, 0);
    applyStimulus();
    for (int k = 0; k < NDUT; k++) checkField("hole_addr", k, int'(insAddr[k]), 5);
    driveInputs(0, 0, 0, 0, 0, 0, 1, 'h3C);
    applyStimulus();
    for (int k = 0; k < NDUT; k++) begin
      checkField("hole_dout", k, int'(dout[k]), 5);
      checkField("hole_hit",  k, int'(hit[k]), 1);
    end

    // Duplicate insert, then reset in the middle of activity.
    doReset();
    driveInputs(0, 0, 1, 0, 0, 'h11, 0, 0);
    applyStimulus();
    driveInputs(0, 0, 1, 0, 0, 'h11, 0, 0);
    applyStimulus();
    checkField("dup_flag",   1, int'(insDup[1]), 1);
    checkField("dup_addr",   1, int'(insAddr[1]), 0);
    checkField("dup_count",  1, int'(count[1]), 1);
    checkField("nodup_addr", 0, int'(insAddr[0]), 1);
    driveInputs(0, 0, 1, 0, 0, 'h22, 1, 'h11);
    applyStimulus();
    doReset();
    driveInputs(0, 0, 0, 0, 0, 0, 1, 'h11);
    applyStimulus();
    for (int k = 0; k < NDUT; k++) checkField("post_rst_hit", k, int'(hit[k]), 0);

    // Randomised traffic on a small key space so hits and dups are common.
    doReset();
    for (int n = 0; n < 400; n++) begin
      driveInputs($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 35, $urandom_range(0, 99) < 15,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 70, int'($urandom_range(0, 7)));
      applyStimulus();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
